// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int SUB_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, busy
  );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full-subtractor cell: diff = x - y - z, borrow out when the result goes negative.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic diff,
  output logic borrow
);

  assign diff   = x ^ y ^ z;
  assign borrow = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor d = a - b - bin, LSB first through one full_sub cell,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t         state_reg, state_next;
  logic [W-1:0]   a_sh_reg, a_sh_next;
  logic [W-1:0]   b_sh_reg, b_sh_next;
  logic [W-1:0]   d_sh_reg, d_sh_next;
  logic [W-1:0]   d_out_reg, d_out_next;
  logic           br_reg, br_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           a_msb_reg, a_msb_next;
  logic           b_msb_reg, b_msb_next;
  logic           bout_reg, bout_next;
  logic           ovf_reg, ovf_next;

  logic           cell_diff;
  logic           cell_borrow;
  logic [W:0]     d_cat;

  full_sub u_cell (
    .x      (a_sh_reg[0]),
    .y      (b_sh_reg[0]),
    .z      (br_reg),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  // Concatenate-then-select keeps the right shift legal for W=1.
  assign d_cat = {cell_diff, d_sh_reg};

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    d_sh_next  = d_sh_reg;
    d_out_next = d_out_reg;
    br_next    = br_reg;
    cnt_next   = cnt_reg;
    a_msb_next = a_msb_reg;
    b_msb_next = b_msb_reg;
    bout_next  = bout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_next  = bus.a;
          b_sh_next  = bus.b;
          br_next    = bus.bin;
          cnt_next   = '0;
          a_msb_next = bus.a[W-1];
          b_msb_next = bus.b[W-1];
          state_next = RUN;
        end
      end
      RUN: begin
        a_sh_next = a_sh_reg >> 1;
        b_sh_next = b_sh_reg >> 1;
        d_sh_next = d_cat[W:1];
        br_next   = cell_borrow;
        cnt_next  = cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) begin
          // Result registers only change here, so d/bout/ovf stay frozen between operations.
          d_out_next = d_cat[W:1];
          bout_next  = cell_borrow;
          ovf_next   = (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ cell_diff);
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      d_sh_reg  <= '0;
      d_out_reg <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      bout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      d_sh_reg  <= d_sh_next;
      d_out_reg <= d_out_next;
      br_reg    <= br_next;
      cnt_reg   <= cnt_next;
      a_msb_reg <= a_msb_next;
      b_msb_reg <= b_msb_next;
      bout_reg  <= bout_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.d         = d_out_reg;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver queues expected results, monitor pops on output transfer.
module tb_serial_subtractor;
  import sub_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.W(W)) bus ();

  serial_subtractor #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t exp_q[$];
  int   lat_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_ov   = 1'b0;
  logic chk_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] f;
    res_t r;
    f      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    r.d    = f[W-1:0];
    r.bout = f[W];
    r.ovf  = (a[W-1] ^ b[W-1]) & (a[W-1] ^ f[W-1]);
    return r;
  endfunction

  // Monitor: latency, result and handshake checks, sampled on the falling edge.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      prev_ov   = 1'b0;
      chk_ready = 1'b0;
    end else begin
      if (chk_ready) check("in_ready_after_xfer", bus.in_ready, 1);
      chk_ready = 1'b0;
      if (bus.out_valid) check("in_ready_low_in_done", bus.in_ready, 0);
      if (bus.out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL latency: got out_valid with no pending operation, required none");
        end else begin
          check("latency", cyc - lat_q.pop_front(), W);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_result: got d=%h, required no result", bus.d);
        end else begin
          e = exp_q.pop_front();
          $display("result d=%h bout=%b ovf=%b (expected d=%h bout=%b ovf=%b)",
                   bus.d, bus.bout, bus.ovf, e.d, e.bout, e.ovf);
          check("d", bus.d, e.d);
          check("bout", bus.bout, e.bout);
          check("ovf", bus.ovf, e.ovf);
          chk_ready = 1'b1;
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // Called in the posedge+1 phase; returns in the same phase one edge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin_i, input res_t e);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL in_ready_timeout: got in_ready=0, required 1");
      return;
    end
    bus.a = a; bus.b = b; bus.bin = bin_i; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_q.push_back(e);
    lat_q.push_back(cyc);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  logic [W-1:0] va[5]   = '{8'h5A, 8'h00, 8'h80, 8'h10, 8'h7F};
  logic [W-1:0] vb[5]   = '{8'h3C, 8'h01, 8'h01, 8'h0F, 8'hFF};
  logic         vbin[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] vd[5]   = '{8'h1E, 8'hFF, 8'h7F, 8'h00, 8'h80};
  logic         vbo[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         vov[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int   n;
    logic [W-1:0] ra, rb;
    logic rbin;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_d", bus.d, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk); #1;

    // Directed arithmetic vectors.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.d = vd[i]; e.bout = vbo[i]; e.ovf = vov[i];
      send(va[i], vb[i], vbin[i], e);
      drain();
    end

    // Backpressure, with stray in_valid pulses in RUN and DONE.
    bus.out_ready = 1'b0;
    e.d = 8'h22; e.bout = 1'b0; e.ovf = 1'b0;
    send(8'h33, 8'h11, 1'b0, e);
    bus.a = 8'hFF; bus.b = 8'h00; bus.bin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", bus.out_valid, 1);
    bus.a = 8'h44; bus.b = 8'h01; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_d", bus.d, 8'h22);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("bp_no_stray_accept", bus.busy, 0);
    bus.out_ready = 1'b1;

    // Reset three edges into RUN aborts the operation.
    e = model(8'h12, 8'h34, 1'b0);
    send(8'h12, 8'h34, 1'b0, e);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_d", bus.d, 0);
    check("abort_busy", bus.busy, 0);
    @(posedge clk); #1;
    e.d = 8'h64; e.bout = 1'b0; e.ovf = 1'b1;
    send(8'hC8, 8'h64, 1'b0, e);
    drain();

    // Back-to-back random operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      send(ra, rb, rbin, model(ra, rb, rbin));
    end
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing d = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell.
- It is the inverse-direction companion of the combinational full adder: same cell-level arithmetic, but it subtracts.
- It sits in the arithmetic datapath where area matters more than latency.
- Operands are accepted and results returned over valid/ready handshakes.

Parameters:
- W, 8, operand/result width in bits (W >= 1)

Ports:
- clk        input   1  system clock; all state updates on rising edge
- rst        input   1  synchronous, active-high reset
- in_valid   input   1  operand transfer request
- in_ready   output  1  block can accept operands
- a          input   W  minuend, sampled on the input transfer edge
- b          input   W  subtrahend, sampled on the input transfer edge
- bin        input   1  borrow-in, sampled on the input transfer edge
- out_valid  output  1  result available
- out_ready  input   1  consumer accepts the result
- d          output  W  difference, two's complement, modulo 2^W
- bout       output  1  final borrow-out (unsigned a < b + bin)
- ovf        output  1  signed overflow
- busy       output  1  high in RUN or DONE

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - in_ready=1 in the following cycle.
  - out_valid=0, d=0, bout=0, ovf=0, busy=0.
  - Shift registers, borrow flop and counter are cleared.
  - rst has priority over every other event, including a reset mid-RUN or in DONE: the operation is aborted and no result is emitted.
- FSM states:
  - IDLE:
    - in_ready=1, busy=0.
    - On in_valid=1: load a_sh<=a, b_sh<=b, br<=bin, cnt<=0, capture a_msb<=a[W-1] and b_msb<=b[W-1], go to RUN.
  - RUN:
    - in_ready=0, busy=1.
    - Each edge: full-subtract the cell inputs x=a_sh[0], y=b_sh[0], z=br.
      - diff = x^y^z
      - borrow = (~x&y) | (~(x^y)&z)
    - d_sh shifts right with diff entering bit W-1.
    - a_sh and b_sh shift right; br<=borrow; cnt<=cnt+1.
    - On the edge where cnt==W-1: go to DONE and register bout<=borrow.
    - Register ovf <= (a_msb^b_msb) & (a_msb^diff_final), where diff_final is the MSB result bit.
  - DONE:
    - out_valid=1; d, bout and ovf are stable.
    - in_ready=0.
    - On out_ready=1: go to IDLE, out_valid=0 next cycle.
    - d/bout/ovf hold their last values until the next result.
- Latency: out_valid rises exactly W edges after the input-transfer edge.
  - Example: W=8, accept at edge 0, out_valid visible after edge 8.
- Throughput: one operation per W+2 cycles minimum. No accept in the same cycle as output completion.
- Handshake rules:
  - in_valid in RUN or DONE is ignored; operands are not sampled.
  - out_valid, once high, stays high with constant d until out_ready=1.
  - in_ready and out_valid are never both high.
- Arithmetic:
  - Result is modulo 2^W. bout=1 iff {a} < {b}+bin as unsigned values.
  - W=1 degenerates to a single-cycle RUN.
- Counter: width $clog2(W+1). No wrap is possible because RUN exits at W-1.

Decomposition:
- Package sub_pkg holds:
  - the state enum {IDLE, RUN, DONE} (2 bits)
  - the default width constant SUB_W_DEFAULT = 8
- Sub-module full_sub: purely combinational one-bit cell (x, y, z -> diff, borrow). It is instantiated once and is reusable by parallel subtractors.

Test Plan:
1. a=8'h5A, b=8'h3C, bin=0 -> out_valid 8 edges after accept; d=8'h1E, bout=0, ovf=0.
2. a=8'h00, b=8'h01, bin=0 -> d=8'hFF, bout=1, ovf=0. Then a=8'h80, b=8'h01 -> d=8'h7F, bout=0, ovf=1.
3. a=8'h10, b=8'h0F, bin=1 -> d=8'h00, bout=0, ovf=0. Then a=8'h7F, b=8'hFF, bin=0 -> d=8'h80, bout=1, ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and d stays constant. Pulse in_valid with new operands during RUN and DONE -> ignored, and the result matches the first operands.
5. Assert rst for one cycle after 3 RUN edges -> next cycle state IDLE, in_ready=1, out_valid=0, d=0. A subsequent a=8'hC8, b=8'h64 -> d=8'h64, bout=0, ovf=1.
6. Back-to-back with out_ready tied high: 20 random operand pairs -> each result matches the reference model a-b-bin. in_ready returns exactly 1 cycle after each output transfer.
